// File: rtl/famicom_bus_pkg.sv
// Shared constants and request type for the Famicom cartridge CPU bus master and its bench models.
package famicom_bus_pkg;

    localparam int unsigned PHI1_CLKS_DEFAULT = 15;
    localparam int unsigned PHI2_CLKS_DEFAULT = 13;

    // Phase indices: K_HOLD keeps the previous bus state, K_APPLY shows the new one.
    localparam int unsigned K_HOLD  = 0;
    localparam int unsigned K_APPLY = 1;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
    } bus_req_t;

    function automatic int unsigned phase_count(input int unsigned phi1, input int unsigned phi2);
        return phi1 + phi2;
    endfunction

endpackage

// File: rtl/m2_phase_gen.sv
// Free-running bus-cycle phase counter producing registered M2 and phase strobes.
module m2_phase_gen
    import famicom_bus_pkg::*;
#(
    parameter int unsigned PHI1_CLKS = PHI1_CLKS_DEFAULT,
    parameter int unsigned PHI2_CLKS = PHI2_CLKS_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic m2_o,
    output logic k_first_o,
    output logic k_apply_o,
    output logic k_last_o
);

    localparam int unsigned N  = phase_count(PHI1_CLKS, PHI2_CLKS);
    localparam int unsigned KW = $clog2(N);

    localparam logic [KW-1:0] KLast  = KW'(N - 1);
    localparam logic [KW-1:0] KM2    = KW'(PHI1_CLKS);
    localparam logic [KW-1:0] KHold  = KW'(K_HOLD);
    localparam logic [KW-1:0] KApply = KW'(K_APPLY);

    logic [KW-1:0] k_q, k_d;
    logic          m2_q, k_first_q, k_apply_q, k_last_q;

    always_comb begin
        k_d = (k_q == KLast) ? '0 : k_q + KW'(1);
    end

    // Outputs are decoded from k_d so that they line up with k_q after the edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            k_q       <= '0;
            m2_q      <= 1'b0;
            k_first_q <= 1'b1;
            k_apply_q <= 1'b0;
            k_last_q  <= 1'b0;
        end else begin
            k_q       <= k_d;
            m2_q      <= (k_d >= KM2);
            k_first_q <= (k_d == KHold);
            k_apply_q <= (k_d == KApply);
            k_last_q  <= (k_d == KLast);
        end
    end

    assign m2_o      = m2_q;
    assign k_first_o = k_first_q;
    assign k_apply_o = k_apply_q;
    assign k_last_o  = k_last_q;

endmodule

// File: rtl/famicom_cpu_bus_master.sv
// Console-side Famicom CPU bus initiator: request/response handshake to phased M2, /ROMSEL,
// R/W, address and data activity, with continuously running M2 and a synchronized /IRQ.
module famicom_cpu_bus_master
    import famicom_bus_pkg::*;
#(
    parameter int unsigned PHI1_CLKS = PHI1_CLKS_DEFAULT,
    parameter int unsigned PHI2_CLKS = PHI2_CLKS_DEFAULT,
    parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_rw,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        m2,
    output logic        romsel,
    output logic        cpu_rw,
    output logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_oe,
    input  logic [7:0]  cpu_data_in,
    input  logic        irq_n,
    output logic        irq_active
);

    logic k_first, k_apply, k_last;

    m2_phase_gen #(
        .PHI1_CLKS (PHI1_CLKS),
        .PHI2_CLKS (PHI2_CLKS)
    ) u_phase (
        .clk_i     (clk),
        .reset_i   (reset),
        .m2_o      (m2),
        .k_first_o (k_first),
        .k_apply_o (k_apply),
        .k_last_o  (k_last)
    );

    bus_req_t    pend_q;
    logic        pend_full_q;
    logic        active_q;
    logic [15:0] addr_q;
    logic        rw_q;
    logic        oe_q;
    logic [7:0]  dout_q;
    logic [7:0]  rdata_q;
    logic        resp_valid_q;
    logic [1:0]  irq_sync_q;

    logic        accept;
    logic        apply;
    bus_req_t    req_in;
    bus_req_t    src;

    always_comb begin
        req_in    = '{addr: req_addr, rw: req_rw, wdata: req_wdata};
        req_ready = ~pend_full_q & ~reset;
        accept    = req_valid & req_ready;
        // A request accepted in the k==0 clk is bypassed straight onto the bus.
        apply     = pend_full_q | accept;
        src       = pend_full_q ? pend_q : req_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            active_q     <= 1'b0;
            addr_q       <= IDLE_ADDR;
            rw_q         <= 1'b1;
            oe_q         <= 1'b0;
            dout_q       <= 8'h00;
            rdata_q      <= 8'h00;
            resp_valid_q <= 1'b0;
            irq_sync_q   <= 2'b11;
        end else begin
            // The entry stays visible through k==1 so req_ready is low while it drains.
            if (accept) begin
                pend_q      <= req_in;
                pend_full_q <= 1'b1;
            end else if (k_apply) begin
                pend_full_q <= 1'b0;
            end

            if (k_first) begin
                active_q <= apply;
                if (apply) begin
                    addr_q <= src.addr;
                    rw_q   <= src.rw;
                    oe_q   <= ~src.rw;
                    if (!src.rw) begin
                        dout_q <= src.wdata;
                    end
                end else begin
                    addr_q <= IDLE_ADDR;
                    rw_q   <= 1'b1;
                    oe_q   <= 1'b0;
                end
            end

            resp_valid_q <= k_last & active_q;
            if (k_last && active_q && rw_q) begin
                rdata_q <= cpu_data_in;
            end

            irq_sync_q <= {irq_sync_q[0], irq_n};
        end
    end

    assign romsel       = ~(addr_q[15] & m2);
    assign cpu_rw       = rw_q;
    assign cpu_addr     = addr_q[14:0];
    assign cpu_data_out = dout_q;
    assign cpu_data_oe  = oe_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = rdata_q;
    assign irq_active   = ~irq_sync_q[1];

endmodule

// File: tb/tb_famicom_cpu_bus_master.sv
// Randomized bench for famicom_cpu_bus_master against a bus-cycle schedule model.
module tb_famicom_cpu_bus_master;
    import famicom_bus_pkg::*;

    localparam int P1 = 15;
    localparam int P2 = 13;
    localparam int N  = P1 + P2;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, req_rw, resp_valid;
    logic        m2, romsel, cpu_rw, cpu_data_oe, irq_n, irq_active;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata, resp_rdata, cpu_data_out, cpu_data_in;
    logic [14:0] cpu_addr;

    always #5 clk = ~clk;

    famicom_cpu_bus_master #(
        .PHI1_CLKS (P1),
        .PHI2_CLKS (P2),
        .IDLE_ADDR (16'h0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_rw       (req_rw),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .m2           (m2),
        .romsel       (romsel),
        .cpu_rw       (cpu_rw),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_data_oe  (cpu_data_oe),
        .cpu_data_in  (cpu_data_in),
        .irq_n        (irq_n),
        .irq_active   (irq_active)
    );

    // Model: clk t since reset release (k = t mod N); bus cycle c spans t = cN+1 .. cN+N.
    int         vectors = 0;
    int         miscompares = 0;
    int         t = 0;
    bit         known = 0;
    bit         rst_prev = 0;
    bus_req_t   sched [int];
    bit         pend = 0;
    int         acc_t = 0;
    int         clr_t = 0;
    logic [7:0] dout_m = 8'h00;
    logic [7:0] rdata_m = 8'h00;
    bit         h1 = 1;
    bit         h2 = 1;
    bus_req_t   idle_r = '{addr: 16'h0000, rw: 1'b1, wdata: 8'h00};
    bus_req_t   nr = '{addr: 16'h0000, rw: 1'b1, wdata: 8'h00};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic step(input bit rst, input bit v, input bus_req_t r, input logic [7:0] din,
                        input bit irqn, output bit acc);
        int       k, cc, c;
        bit       has, exp_rdy, busy, exp_m2;
        bus_req_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        req_valid   = v;
        req_addr    = r.addr;
        req_rw      = r.rw;
        req_wdata   = r.wdata;
        cpu_data_in = din;
        irq_n       = irqn;
        @(negedge clk);
        t = rst_prev ? 0 : t + 1;
        k = t % N;
        has = 0;
        e = idle_r;
        if (!rst_prev && t >= 1) begin
            cc  = (t - 1) / N;
            has = sched.exists(cc);
            if (has) e = sched[cc];
        end
        exp_m2  = (k >= P1);
        busy    = pend && (t > acc_t) && (t <= clr_t);
        exp_rdy = !rst && !busy;
        if (known) begin
            check_eq("m2", 32'(m2), 32'(exp_m2));
            check_eq("romsel", 32'(romsel), 32'(!(e.addr[15] && exp_m2)));
            check_eq("cpu_rw", 32'(cpu_rw), 32'(e.rw));
            check_eq("cpu_addr", 32'(cpu_addr), 32'(e.addr[14:0]));
            check_eq("cpu_data_oe", 32'(cpu_data_oe), 32'(has && !e.rw));
            check_eq("cpu_data_out", 32'(cpu_data_out), 32'(dout_m));
            check_eq("resp_valid", 32'(resp_valid),
                     32'(k == 0 && t >= N && sched.exists(t / N - 1)));
            check_eq("resp_rdata", 32'(resp_rdata), 32'(rdata_m));
            check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
            check_eq("irq_active", 32'(irq_active), 32'(!h2));
        end
        acc = known && !rst && v && exp_rdy;
        if (acc) begin
            c = (t + N - 1) / N;
            sched[c] = r;
            pend  = 1;
            acc_t = t;
            clr_t = c * N + 1;
        end
        if (rst) begin
            sched.delete();
            pend    = 0;
            dout_m  = 8'h00;
            rdata_m = 8'h00;
            h1      = 1;
            h2      = 1;
        end else begin
            if (k == N - 1 && has && e.rw) rdata_m = din;
            if (k == 0) begin
                c = t / N;
                if (sched.exists(c) && !sched[c].rw) dout_m = sched[c].wdata;
            end
            h2 = h1;
            h1 = irqn;
        end
        known    = 1;
        rst_prev = rst;
    endtask

    task automatic idle(input int n, input logic [7:0] din);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, nr, din, 1'b1, a);
    endtask

    // Holds req_valid until the model sees the handshake; expiry counts as a miscompare.
    task automatic issue(input bus_req_t r, input logic [7:0] din);
        bit a = 0;
        for (int i = 0; i < 3 * N && !a; i++) step(1'b0, 1'b1, r, din, 1'b1, a);
        check_eq("accept", 32'(a), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit       a;
        bus_req_t r;
        int       target;
        bit       irq_state;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_rw = 1'b1; req_wdata = '0;
        cpu_data_in = '0; irq_n = 1'b1;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, nr, 8'h00, 1'b1, a);
        idle(3 * N, 8'h00);

        r = '{addr: 16'h8123, rw: 1'b1, wdata: 8'h00};
        issue(r, 8'hA5);
        idle(2 * N, 8'hA5);

        r = '{addr: 16'h6000, rw: 1'b0, wdata: 8'h3C};
        issue(r, 8'h11);
        idle(2 * N, 8'h22);

        for (int i = 0; i < 4; i++) begin
            r = '{addr: 16'(16'h8000 + i * 16'h0111), rw: i[0], wdata: 8'(8'hC0 + i)};
            issue(r, 8'(8'h50 + i));
        end
        idle(2 * N, 8'h77);

        // Reset landing at k = 20 of an active write.
        r = '{addr: 16'hFFF0, rw: 1'b0, wdata: 8'h55};
        issue(r, 8'h00);
        target = ((acc_t + N - 1) / N) * N + 20;
        for (int i = 0; i < 3 * N && t + 1 != target; i++) step(1'b0, 1'b0, nr, 8'h00, 1'b1, a);
        check_eq("reset_align", 32'(t + 1), 32'(target));
        step(1'b1, 1'b0, nr, 8'h00, 1'b1, a);
        step(1'b1, 1'b0, nr, 8'h00, 1'b1, a);
        idle(N, 8'h00);
        r = '{addr: 16'hC00F, rw: 1'b1, wdata: 8'h00};
        issue(r, 8'h9E);
        idle(2 * N, 8'h9E);

        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, nr, 8'h00, 1'b0, a);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, nr, 8'h00, 1'b1, a);

        irq_state = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r.addr  = 16'($urandom);
            r.rw    = 1'($urandom);
            r.wdata = 8'($urandom);
            if ($urandom_range(0, 19) == 0) irq_state = ~irq_state;
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0), r, 8'($urandom),
                 irq_state, a);
        end
        idle(2 * N, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
